decode_queue: RTL and testbench

- Parametrised N-lane instruction buffer between fetch and decode in the superscalar MIPS pipeline.
- Replaces the fixed two-lane decode pipeline register with a circular queue.
- Fetch pushes up to WIDTH {PCPlus4, Instr} pairs per cycle; decode pops 0..WIDTH from the head.
- Partial issue is supported: unconsumed instructions shift into lower output lanes, in order.

---
 rtl/decode_pkg.sv | 31 +++
 rtl/decode_queue_mem.sv | 34 +++
 rtl/decode_queue.sv | 126 ++++++++++++
 tb/tb_decode_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and helpers for the fetch/decode instruction queue.
// Imported by the queue top level and its storage array.
package decode_pkg;

  localparam int WIDTH_DEF = 2;
  localparam int DEPTH_DEF = 8;
  localparam int DW_DEF    = 32;

  typedef struct packed {
    logic [DW_DEF-1:0] pcplus4;
    logic [DW_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic int unsigned popcount(
    input logic [31:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++)
      n += 32'(v[i]);
    return n;
  endfunction

  function automatic int unsigned umin(
    input int unsigned a,
    input int unsigned b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/decode_queue_mem.sv
// Queue storage: WIDTH writes at consecutive slots,
// WIDTH reads from consecutive slots, no data reset.
module decode_queue_mem
  import decode_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = fetch_entry_t,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic [WIDTH-1:0]   we,
  input  logic [PW-1:0]      waddr,
  input  T     [WIDTH-1:0]   wdata,
  input  logic [PW-1:0]      raddr,
  output T     [WIDTH-1:0]   rdata
);

  T ram [DEPTH];

  // Lane i lands at base+i; addresses wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++)
      if (we[i])
        ram[waddr + PW'(i)] <= wdata[i];
  end

  // Lane i reads the entry i slots past the head.
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      rdata[i] = ram[raddr + PW'(i)];
  end

endmodule

// File: rtl/decode_queue.sv
// N-lane circular instruction queue between fetch and decode.
// Partial issue shifts unconsumed entries into lower lanes.
module decode_queue
  import decode_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  localparam int KW   = $clog2(WIDTH+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [WIDTH-1:0]    InValid,
  input  logic [WIDTH*DW-1:0] InPCPlus4,
  input  logic [WIDTH*DW-1:0] InInstr,
  output logic                InReady,
  output logic [WIDTH-1:0]    OutValid,
  output logic [WIDTH*DW-1:0] OutPCPlus4,
  output logic [WIDTH*DW-1:0] OutInstr,
  input  logic [KW-1:0]       Consume
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DW-1:0] pcplus4;
    logic [DW-1:0] instr;
  } entry_t;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic [KW-1:0]    avail;
  logic [KW-1:0]    push_n;
  logic [KW-1:0]    pop_n;
  logic [WIDTH-1:0] we;
  entry_t [WIDTH-1:0] wdata;
  entry_t [WIDTH-1:0] rdata;

  decode_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  // Ready and transfer sizes from registered count only.
  always_comb begin
    free    = CW'(DEPTH) - count;
    InReady = free >= CW'(WIDTH);
    avail   = (count >= CW'(WIDTH)) ?
              KW'(WIDTH) : KW'(count);
    push_n  = '0;
    pop_n   = '0;
    if (!Stall && !Flush) begin
      if (InReady)
        push_n = KW'(popcount(32'(InValid)));
      pop_n = KW'(umin(32'(Consume),
                       32'(avail)));
    end
  end

  // Unpack fetch lanes; only the first push_n are written.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      wdata[i].pcplus4 = InPCPlus4[i*DW +: DW];
      wdata[i].instr   = InInstr[i*DW +: DW];
      we[i]            = KW'(i) < push_n;
    end
  end

  // Pointers and occupancy; flush wins over stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (!Stall) begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Invalid lanes are driven to zero.
  always_comb begin
    OutValid   = '0;
    OutPCPlus4 = '0;
    OutInstr   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) < count) begin
        OutValid[i]             = 1'b1;
        OutPCPlus4[i*DW +: DW]  = rdata[i].pcplus4;
        OutInstr[i*DW +: DW]    = rdata[i].instr;
      end
    end
  end

  // Protocol checks; behaviour does not depend on them.
  always @(posedge clk) begin
    if (reset) begin
      assert (count <= CW'(DEPTH))
        else $error("queue count above depth");
      if (!Stall && !Flush)
        assert (32'(Consume) <= 32'(count))
          else $warning("consume exceeds count");
      assert ((InValid & (InValid + WIDTH'(1))) == '0)
        else $warning("push valid not contiguous");
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: vector table, wrap sequence,
// async reset, and random traffic against a queue model.
module tb_decode_queue;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  InValid = '0;
  logic [63:0] InPCPlus4 = '0;
  logic [63:0] InInstr = '0;
  logic        InReady;
  logic [1:0]  OutValid;
  logic [63:0] OutPCPlus4;
  logic [63:0] OutInstr;
  logic [1:0]  Consume = '0;

  decode_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .Flush      (Flush),
    .InValid    (InValid),
    .InPCPlus4  (InPCPlus4),
    .InInstr    (InInstr),
    .InReady    (InReady),
    .OutValid   (OutValid),
    .OutPCPlus4 (OutPCPlus4),
    .OutInstr   (OutInstr),
    .Consume    (Consume)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        st;
    logic        fl;
    logic [1:0]  iv;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  cons;
    logic [1:0]  ev;
    logic        er;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [1:0]  ev;
    logic [63:0] ei;
    logic [63:0] ep;
    logic        er;
    ev = '0;
    ei = '0;
    ep = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i < q.size()) begin
        ev[i] = 1'b1;
        ei[i*32 +: 32] = q[i].instr;
        ep[i*32 +: 32] = q[i].pc;
      end
    er = (DEPTH - q.size()) >= WIDTH;
    chk({tag, " model valid"}, 64'(OutValid), 64'(ev));
    chk({tag, " model ready"}, 64'(InReady), 64'(er));
    chk({tag, " model instr"}, OutInstr, ei);
    chk({tag, " model pc"}, OutPCPlus4, ep);
  endtask

  task automatic step(input logic st,
                      input logic fl,
                      input logic [1:0] iv,
                      input logic [31:0] i0,
                      input logic [31:0] i1,
                      input logic [1:0] cons,
                      input string tag);
    int   npop;
    int   npush;
    logic rdy;
    ent_t e;
    @(negedge clk);
    Stall     = st;
    Flush     = fl;
    InValid   = iv;
    InInstr   = {i1, i0};
    InPCPlus4 = {i1 + 32'h1000, i0 + 32'h1000};
    Consume   = cons;
    rdy = (DEPTH - q.size()) >= WIDTH;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else if (!st) begin
      npop = int'(cons);
      if (npop > q.size()) npop = q.size();
      if (npop > WIDTH) npop = WIDTH;
      repeat (npop) void'(q.pop_front());
      npush = $countones(iv);
      if (rdy)
        for (int i = 0; i < npush; i++) begin
          e.instr = InInstr[i*32 +: 32];
          e.pc    = InPCPlus4[i*32 +: 32];
          q.push_back(e);
        end
    end
    #1;
    chk_model(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    Stall   = 1'b0;
    Flush   = 1'b0;
    InValid = '0;
    Consume = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,0,2'b11,32'hA,32'hB,2'd0,2'b11,1,32'hA,32'hB};
    tbl[1]  = '{0,0,2'b00,32'h0,32'h0,2'd1,2'b01,1,32'hB,32'h0};
    tbl[2]  = '{0,0,2'b00,32'h0,32'h0,2'd1,2'b00,1,32'h0,32'h0};
    tbl[3]  = '{0,0,2'b11,32'hA,32'hB,2'd0,2'b11,1,32'hA,32'hB};
    tbl[4]  = '{0,0,2'b11,32'hC,32'hD,2'd0,2'b11,0,32'hA,32'hB};
    tbl[5]  = '{0,0,2'b11,32'hE,32'hF,2'd0,2'b11,0,32'hA,32'hB};
    tbl[6]  = '{0,0,2'b00,32'h0,32'h0,2'd2,2'b11,1,32'hC,32'hD};
    tbl[7]  = '{1,0,2'b11,32'h11,32'h12,2'd2,2'b11,1,32'hC,32'hD};
    tbl[8]  = '{1,1,2'b11,32'h13,32'h14,2'd0,2'b00,1,32'h0,32'h0};
    tbl[9]  = '{0,0,2'b00,32'h0,32'h0,2'd0,2'b00,1,32'h0,32'h0};
    tbl[10] = '{0,0,2'b01,32'h20,32'h0,2'd0,2'b01,1,32'h20,32'h0};
    tbl[11] = '{0,0,2'b11,32'h21,32'h22,2'd0,2'b11,0,32'h20,32'h21};
    tbl[12] = '{0,0,2'b01,32'h23,32'h0,2'd0,2'b11,0,32'h20,32'h21};
    tbl[13] = '{0,0,2'b00,32'h0,32'h0,2'd1,2'b11,1,32'h21,32'h22};
    tbl[14] = '{0,0,2'b00,32'h0,32'h0,2'd3,2'b00,1,32'h0,32'h0};
    tbl[15] = '{0,0,2'b01,32'h30,32'h0,2'd0,2'b01,1,32'h30,32'h0};
    tbl[16] = '{0,0,2'b00,32'h0,32'h0,2'd2,2'b00,1,32'h0,32'h0};
    tbl[17] = '{0,0,2'b10,32'h40,32'h41,2'd0,2'b01,1,32'h40,32'h0};
    tbl[18] = '{0,0,2'b00,32'h0,32'h0,2'd1,2'b00,1,32'h0,32'h0};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset valid", 64'(OutValid), 64'(0));
    chk("reset ready", 64'(InReady), 64'(1));
    chk("reset instr", OutInstr, 64'(0));
    chk("reset pc", OutPCPlus4, 64'(0));

    for (int k = 0; k < 19; k++) begin
      step(tbl[k].st, tbl[k].fl, tbl[k].iv,
           tbl[k].i0, tbl[k].i1, tbl[k].cons,
           $sformatf("vec%0d", k));
      chk($sformatf("vec%0d valid", k),
          64'(OutValid), 64'(tbl[k].ev));
      chk($sformatf("vec%0d ready", k),
          64'(InReady), 64'(tbl[k].er));
      chk($sformatf("vec%0d lane0", k),
          64'(OutInstr[31:0]), 64'(tbl[k].e0));
      chk($sformatf("vec%0d lane1", k),
          64'(OutInstr[63:32]), 64'(tbl[k].e1));
    end

    step(0, 0, 2'b11, 32'd0, 32'd1, 2'd0, "wrap0");
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 2'b11, 32'(2*k), 32'(2*k+1), 2'd2,
           $sformatf("wrap%0d", k));
      chk($sformatf("wrap%0d valid", k),
          64'(OutValid), 64'(2'b11));
      chk($sformatf("wrap%0d lane0", k),
          64'(OutInstr[31:0]), 64'(2*k));
      chk($sformatf("wrap%0d lane1", k),
          64'(OutInstr[63:32]), 64'(2*k+1));
    end
    step(0, 0, 2'b00, 32'd0, 32'd0, 2'd2, "drain");

    step(0, 0, 2'b11, 32'h50, 32'h51, 2'd0, "fill0");
    step(0, 0, 2'b01, 32'h52, 32'h0, 2'd0, "fill1");
    chk("fill count3 valid", 64'(OutValid), 64'(2'b11));
    chk("fill count3 ready", 64'(InReady), 64'(0));
    idle();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset valid", 64'(OutValid), 64'(0));
    chk("async reset ready", 64'(InReady), 64'(1));
    chk("async reset instr", OutInstr, 64'(0));
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_model("post reset");

    for (int k = 0; k < 400; k++) begin
      logic [1:0] iv;
      int r;
      r = $urandom_range(0, 2);
      iv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      step($urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0,
           iv, $urandom, $urandom,
           2'($urandom_range(0, 3)),
           $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
